slew_limiter: RTL

SLEW_LIMITER -- requirements
Module: slew_limiter

---
 rtl/slew_limiter_pkg.sv | 31 +++
 rtl/slew_limiter_if.sv | 14 +
 rtl/slew_settle_ctr.sv | 36 +++
 rtl/slew_limiter.sv | 98 +++++++++
 4 files changed

// File: rtl/slew_limiter_pkg.sv
// Shared types, constants and fixed-point "real" helper macros for the slew limiter.
// A real format is a signed fixed-point pair: _ib integer bits (sign included) and _fb fraction bits.
`ifndef SLEW_FX_MACROS
`define SLEW_FX_MACROS
`define FX_FMT(name_ib, name_fb, ib, fb) parameter int unsigned name_ib = ib, parameter int unsigned name_fb = fb
`define FX_PASS(name_ib, name_fb, src_ib, src_fb) .name_ib(src_ib), .name_fb(src_fb)
`define FX_CONST(r, fb) ($rtoi(((r) * (2.0 ** (fb))) + (((r) < 0.0) ? -0.5 : 0.5)))
`define FX_ADD(a, b) ((a) + (b))
`define FX_SUB(a, b) ((a) - (b))
`define FX_LT(a, b) ((a) < (b))
`define FX_GT(a, b) ((a) > (b))
`define FX_MIN(a, b) (`FX_LT(a, b) ? (a) : (b))
`define FX_MAX(a, b) (`FX_GT(a, b) ? (a) : (b))
`endif

package slew_pkg;

    typedef enum logic [1:0] {
        StTrack = 2'b00,
        StRise  = 2'b01,
        StFall  = 2'b10
    } slew_state_e;

    // Wide enough for the largest legal settle_cycles (255).
    localparam int unsigned SettleW = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slew_limiter_if.sv
// Target/result bundle between the upstream stage and the slew limiter.
interface slew_limiter_if #(
    parameter int unsigned in_w  = 15,
    parameter int unsigned out_w = 11
);
    logic                    cke;
    logic signed [in_w-1:0]  in;
    logic signed [out_w-1:0] out;
    logic [1:0]              dir;
    logic                    settled;

    modport master (output cke, output in, input out, input dir, input settled);
    modport slave  (input cke, input in, output out, output dir, output settled);
endinterface

// File: rtl/slew_settle_ctr.sv
// Saturating count of consecutive tracking cycles; done once the limit is reached.
module slew_settle_ctr
    import slew_pkg::*;
#(
    parameter int unsigned settle_cycles = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cke,
    input  logic clr,
    input  logic inc,
    output logic done
);
    localparam logic [SettleW-1:0] limit = SettleW'(settle_cycles);

    logic [SettleW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != limit)) begin
            count_d = count_q + SettleW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (cke) begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == limit);
endmodule

// File: rtl/slew_limiter.sv
// Rate limiter: out moves toward in by at most step per enabled cycle, saturating to the
// out format, and reports direction plus a settled flag after a run of tracking cycles.
module slew_limiter
    import slew_pkg::*;
#(
    parameter real         step          = 0.5,
    parameter real         init          = 0.0,
    parameter int unsigned settle_cycles = 4,
    `FX_FMT(in_ib, in_fb, 5, 10),
    `FX_FMT(out_ib, out_fb, 3, 8)
) (
    input logic           clk,
    input logic           rst,
    slew_limiter_if.slave bus
);
    localparam int unsigned in_w    = in_ib + in_fb;
    localparam int unsigned out_w   = out_ib + out_fb;
    localparam int unsigned fb_max  = max_u(in_fb, out_fb);
    localparam int unsigned ib_max  = max_u(in_ib, out_ib);
    localparam int unsigned wide_w  = ib_max + fb_max;
    localparam int unsigned diff_w  = out_w + 1;
    localparam int unsigned in_shl  = fb_max - in_fb;
    localparam int unsigned out_shr = fb_max - out_fb;

    localparam int step_int = `FX_CONST(step, out_fb);
    localparam int init_int = `FX_CONST(init, out_fb);

    localparam logic signed [out_w-1:0] step_q  = out_w'(step_int);
    localparam logic signed [out_w-1:0] init_q  = out_w'(init_int);
    localparam logic signed [out_w-1:0] out_max = {1'b0, {(out_w - 1){1'b1}}};
    localparam logic signed [out_w-1:0] out_min = {1'b1, {(out_w - 1){1'b0}}};

    localparam logic signed [wide_w-1:0] out_max_w = wide_w'(out_max);
    localparam logic signed [wide_w-1:0] out_min_w = wide_w'(out_min);
    localparam logic signed [diff_w-1:0] out_max_d = diff_w'(out_max);
    localparam logic signed [diff_w-1:0] out_min_d = diff_w'(out_min);
    localparam logic signed [diff_w-1:0] step_d    = diff_w'(step_q);
    localparam logic signed [diff_w-1:0] nstep_d   = -step_d;

    slew_state_e             state_q, state_d;
    logic signed [out_w-1:0] out_q, out_d;

    logic signed [in_w-1:0]   in_raw;
    logic signed [wide_w-1:0] in_wide, in_al, in_lo, in_sat_w;
    logic signed [out_w-1:0]  in_sat;
    logic signed [diff_w-1:0] diff, rise_sum, fall_sum, rise_lim, fall_lim;

    // Align in onto a grid holding both formats, then requantise (floor) to out's fraction.
    assign in_raw   = bus.in;
    assign in_wide  = wide_w'(in_raw) <<< in_shl;
    assign in_al    = in_wide >>> out_shr;
    assign in_lo    = `FX_MAX(in_al, out_min_w);
    assign in_sat_w = `FX_MIN(in_lo, out_max_w);
    assign in_sat   = out_w'(in_sat_w);

    // One extra bit keeps the difference of two out-format values from overflowing.
    assign diff     = `FX_SUB(diff_w'(in_sat), diff_w'(out_q));
    assign rise_sum = `FX_ADD(diff_w'(out_q), step_d);
    assign fall_sum = `FX_SUB(diff_w'(out_q), step_d);
    assign rise_lim = `FX_MIN(rise_sum, out_max_d);
    assign fall_lim = `FX_MAX(fall_sum, out_min_d);

    always_comb begin
        state_d = StTrack;
        out_d   = in_sat;
        if (`FX_GT(diff, step_d)) begin
            state_d = StRise;
            out_d   = out_w'(rise_lim);
        end else if (`FX_LT(diff, nstep_d)) begin
            state_d = StFall;
            out_d   = out_w'(fall_lim);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= init_q;
            state_q <= StTrack;
        end else if (bus.cke) begin
            out_q   <= out_d;
            state_q <= state_d;
        end
    end

    slew_settle_ctr #(
        .settle_cycles(settle_cycles)
    ) u_settle_ctr (
        .clk (clk),
        .rst (rst),
        .cke (bus.cke),
        .clr (state_d != StTrack),
        .inc (state_d == StTrack),
        .done(bus.settled)
    );

    assign bus.out = out_q;
    assign bus.dir = state_q;
endmodule
